// File: rtl/lane_pkg.sv
// Shared types for the single-lane passage arbiter.
// Arbiter/tracker encodings, lane direction and sensor codes.
package lane_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_IN  = 2'b01,
    GNT_OUT = 2'b10,
    HOLD    = 2'b11
  } arb_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'b00,
    T_1    = 2'b01,
    T_2    = 2'b10,
    T_3    = 2'b11
  } trk_state_t;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_t;

  localparam logic [1:0] S_CLR  = 2'b00;
  localparam logic [1:0] S_OUT  = 2'b10;
  localparam logic [1:0] S_BOTH = 2'b11;
  localparam logic [1:0] S_INN  = 2'b01;

  // Beam that a car breaks first when travelling in direction d.
  function automatic logic [1:0] lead_code(input dir_t d);
    return (d == DIR_IN) ? S_OUT : S_INN;
  endfunction

  function automatic logic [1:0] trail_code(input dir_t d);
    return (d == DIR_IN) ? S_INN : S_OUT;
  endfunction

endpackage

// File: rtl/passage_tracker.sv
// Follows the two-beam sensor sequence of one car in a given direction.
// Pulses complete on the clear code that ends a full passage.
module passage_tracker
  import lane_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       enable,
  input  dir_t       direction,
  input  logic [1:0] Din,
  output logic       complete,
  output logic       idle
);

  trk_state_t state, nxt;
  logic [1:0] c1, c3;

  assign c1   = lead_code(direction);
  assign c3   = trail_code(direction);
  assign idle = (state == T_IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) state <= T_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    complete = 1'b0;
    if (!enable) begin
      nxt = T_IDLE;
    end else begin
      unique case (state)
        T_IDLE: if (Din == c1) nxt = T_1;
        T_1: begin
          if (Din == S_BOTH)     nxt = T_2;
          else if (Din == S_CLR) nxt = T_IDLE;
        end
        T_2: begin
          if (Din == c3)      nxt = T_3;
          else if (Din == c1) nxt = T_1;
        end
        T_3: begin
          if (Din == S_CLR) begin
            nxt      = T_IDLE;
            complete = 1'b1;
          end else if (Din == S_BOTH) begin
            nxt = T_2;
          end
        end
        default: nxt = T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lane_arbiter_fsm.sv
// Single-lane entry/exit arbiter with occupancy count and idle timeout.
// Define LANE_STATS_EN to add the TotalIn / AbortCnt statistics outputs.
module lane_arbiter_fsm
  import lane_pkg::*;
#(
  parameter int CAPACITY = 7,
  parameter int CNT_W    = 3,
  parameter int TIMEOUT  = 15,
  parameter int TMR_W    = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ReqIn,
  input  logic             ReqOut,
  input  logic [1:0]       Din,
  output logic             GrantIn,
  output logic             GrantOut,
  output logic [CNT_W-1:0] Cntr,
  output logic             Full,
  output logic             Empty,
  output logic             Abort
`ifdef LANE_STATS_EN
  ,
  output logic [7:0]       TotalIn,
  output logic [7:0]       AbortCnt
`endif
);

  arb_state_t       state, nxt;
  dir_t             last;
  dir_t             trk_dir;
  logic [TMR_W-1:0] timer;
  logic             granted;
  logic             complete;
  logic             trk_idle;
  logic             timeout;
  logic             elig_in;
  logic             elig_out;

  assign Full     = (Cntr == CNT_W'(CAPACITY));
  assign Empty    = (Cntr == '0);
  assign GrantIn  = (state == GNT_IN);
  assign GrantOut = (state == GNT_OUT);
  assign granted  = GrantIn | GrantOut;
  assign trk_dir  = GrantOut ? DIR_OUT : DIR_IN;
  assign elig_in  = ReqIn & ~Full;
  assign elig_out = ReqOut & ~Empty;
  assign timeout  = granted & trk_idle
                  & (timer == TMR_W'(TIMEOUT - 1));

  passage_tracker u_trk (
    .Clk       (Clk),
    .Rst       (Rst),
    .enable    (granted),
    .direction (trk_dir),
    .Din       (Din),
    .complete  (complete),
    .idle      (trk_idle)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (elig_in && elig_out)
          nxt = (last == DIR_OUT) ? GNT_IN : GNT_OUT;
        else if (elig_in)
          nxt = GNT_IN;
        else if (elig_out)
          nxt = GNT_OUT;
      end
      GNT_IN, GNT_OUT: begin
        if (complete || timeout) nxt = HOLD;
      end
      HOLD:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      last  <= DIR_OUT;
      timer <= '0;
      Cntr  <= '0;
      Abort <= 1'b0;
    end else begin
      state <= nxt;
      Abort <= timeout;
      if (granted && trk_idle && !timeout)
        timer <= timer + TMR_W'(1);
      else
        timer <= '0;
      if (complete) begin
        last <= trk_dir;
        // Saturation is only a guard; eligibility already gates this.
        if (trk_dir == DIR_IN && !Full)
          Cntr <= Cntr + CNT_W'(1);
        else if (trk_dir == DIR_OUT && !Empty)
          Cntr <= Cntr - CNT_W'(1);
      end
    end
  end

`ifdef LANE_STATS_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      TotalIn  <= '0;
      AbortCnt <= '0;
    end else begin
      if (complete && trk_dir == DIR_IN)
        TotalIn <= TotalIn + 8'd1;
      if (timeout && AbortCnt != 8'hFF)
        AbortCnt <= AbortCnt + 8'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_lane_arbiter_fsm.sv
// Scoreboard bench for lane_arbiter_fsm; expected counts are queued
// when a passage is driven and popped once the grant has dropped.
module tb_lane_arbiter_fsm;

  logic       Clk;
  logic       Rst;
  logic       ReqIn;
  logic       ReqOut;
  logic [1:0] Din;
  logic       GrantIn;
  logic       GrantOut;
  logic [2:0] Cntr;
  logic       Full;
  logic       Empty;
  logic       Abort;
`ifdef LANE_STATS_EN
  logic [7:0] TotalIn;
  logic [7:0] AbortCnt;
`endif

  int n_cmp;
  int n_bad;
  int m_cnt;
  int m_total;
  int m_abort;
  int exp_q[$];

  lane_arbiter_fsm dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .ReqIn    (ReqIn),
    .ReqOut   (ReqOut),
    .Din      (Din),
    .GrantIn  (GrantIn),
    .GrantOut (GrantOut),
    .Cntr     (Cntr),
    .Full     (Full),
    .Empty    (Empty),
    .Abort    (Abort)
`ifdef LANE_STATS_EN
    ,
    .TotalIn  (TotalIn),
    .AbortCnt (AbortCnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Drives one full car passage; the expected count is queued up front.
  task automatic drive_passage(input bit is_in);
    logic [1:0] seq [4];
    if (is_in) begin
      seq = '{2'b10, 2'b11, 2'b01, 2'b00};
      if (m_cnt < 7) m_cnt++;
      m_total = (m_total + 1) % 256;
    end else begin
      seq = '{2'b01, 2'b11, 2'b10, 2'b00};
      if (m_cnt > 0) m_cnt--;
    end
    exp_q.push_back(m_cnt);
    for (int i = 0; i < 4; i++) begin
      Din = seq[i];
      cyc(1);
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    ReqIn = 1'b0;
    ReqOut = 1'b0;
    Din = 2'b00;
    cyc(2);
    Rst = 1'b0;
    m_cnt = 0;
    m_total = 0;
    m_abort = 0;
    n_cmp++;
    if ({GrantIn, GrantOut, Abort, Full, Empty} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00001",
               {GrantIn, GrantOut, Abort, Full, Empty});
    end
    n_cmp++;
    if (Cntr !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_cntr: got %0d want 0", Cntr);
    end
  endtask

  task automatic test_entry;
    logic [2:0] ec;
    ReqIn = 1'b1;
    cyc(1);
    n_cmp++;
    if (GrantIn !== 1'b1 || GrantOut !== 1'b0) begin
      n_bad++;
      $display("FAIL entry_grant: got %b%b want 10", GrantIn, GrantOut);
    end
    ReqIn = 1'b0;
    drive_passage(1'b1);
    ec = 3'(exp_q.pop_front());
    n_cmp++;
    if (Cntr !== ec) begin
      n_bad++;
      $display("FAIL entry_cntr: got %0d want %0d", Cntr, ec);
    end
    n_cmp++;
    if (GrantIn !== 1'b0) begin
      n_bad++;
      $display("FAIL entry_drop: got %b want 0", GrantIn);
    end
    cyc(1);
  endtask

  task automatic test_round_robin;
    logic [2:0] ec;
    ReqIn = 1'b1;
    cyc(1);
    ReqIn = 1'b0;
    drive_passage(1'b1);
    ec = 3'(exp_q.pop_front());
    n_cmp++;
    if (Cntr !== ec) begin
      n_bad++;
      $display("FAIL rr_setup_cntr: got %0d want %0d", Cntr, ec);
    end
    cyc(1);
    ReqIn = 1'b1;
    ReqOut = 1'b1;
    cyc(1);
    n_cmp++;
    if (GrantOut !== 1'b1 || GrantIn !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_first_out: got %b%b want 01", GrantIn, GrantOut);
    end
    drive_passage(1'b0);
    ec = 3'(exp_q.pop_front());
    n_cmp++;
    if (Cntr !== ec || GrantOut !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_exit_done: got cnt %0d go %b want %0d 0",
               Cntr, GrantOut, ec);
    end
    cyc(1);
    n_cmp++;
    if (GrantIn !== 1'b0 || GrantOut !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_hold_gap: got %b%b want 00", GrantIn, GrantOut);
    end
    cyc(1);
    n_cmp++;
    if (GrantIn !== 1'b1 || GrantOut !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_next_in: got %b%b want 10", GrantIn, GrantOut);
    end
    ReqIn = 1'b0;
    ReqOut = 1'b0;
    drive_passage(1'b1);
    ec = 3'(exp_q.pop_front());
    n_cmp++;
    if (Cntr !== ec) begin
      n_bad++;
      $display("FAIL rr_in_cntr: got %0d want %0d", Cntr, ec);
    end
    cyc(1);
  endtask

  task automatic test_full_empty;
    logic [2:0] ec;
    for (int k = 0; k < 5; k++) begin
      ReqIn = 1'b1;
      cyc(1);
      ReqIn = 1'b0;
      n_cmp++;
      if (GrantIn !== 1'b1) begin
        n_bad++;
        $display("FAIL fill_grant[%0d]: got %b want 1", k, GrantIn);
      end
      drive_passage(1'b1);
      ec = 3'(exp_q.pop_front());
      n_cmp++;
      if (Cntr !== ec) begin
        n_bad++;
        $display("FAIL fill_cntr[%0d]: got %0d want %0d", k, Cntr, ec);
      end
      cyc(1);
    end
    n_cmp++;
    if (Full !== 1'b1 || Empty !== 1'b0) begin
      n_bad++;
      $display("FAIL full_flag: got F%b E%b want F1 E0", Full, Empty);
    end
    ReqIn = 1'b1;
    cyc(3);
    n_cmp++;
    if (GrantIn !== 1'b0) begin
      n_bad++;
      $display("FAIL full_block: got %b want 0", GrantIn);
    end
    ReqOut = 1'b1;
    cyc(1);
    n_cmp++;
    if (GrantOut !== 1'b1 || GrantIn !== 1'b0) begin
      n_bad++;
      $display("FAIL full_out_only: got %b%b want 01", GrantIn, GrantOut);
    end
    ReqIn = 1'b0;
    ReqOut = 1'b0;
    drive_passage(1'b0);
    ec = 3'(exp_q.pop_front());
    n_cmp++;
    if (Cntr !== ec) begin
      n_bad++;
      $display("FAIL full_exit_cntr: got %0d want %0d", Cntr, ec);
    end
    cyc(1);
    for (int k = 0; k < 6; k++) begin
      ReqOut = 1'b1;
      cyc(1);
      ReqOut = 1'b0;
      n_cmp++;
      if (GrantOut !== 1'b1) begin
        n_bad++;
        $display("FAIL drain_grant[%0d]: got %b want 1", k, GrantOut);
      end
      drive_passage(1'b0);
      ec = 3'(exp_q.pop_front());
      n_cmp++;
      if (Cntr !== ec) begin
        n_bad++;
        $display("FAIL drain_cntr[%0d]: got %0d want %0d", k, Cntr, ec);
      end
      cyc(1);
    end
    n_cmp++;
    if (Empty !== 1'b1 || Full !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_flag: got F%b E%b want F0 E1", Full, Empty);
    end
    ReqOut = 1'b1;
    cyc(3);
    n_cmp++;
    if (GrantOut !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_block: got %b want 0", GrantOut);
    end
    ReqOut = 1'b0;
    cyc(1);
  endtask

  task automatic test_timeout;
    ReqIn = 1'b1;
    cyc(1);
    ReqIn = 1'b0;
    Din = 2'b00;
    cyc(14);
    n_cmp++;
    if (GrantIn !== 1'b1 || Abort !== 1'b0) begin
      n_bad++;
      $display("FAIL to_early: got g%b a%b want g1 a0", GrantIn, Abort);
    end
    cyc(1);
    m_abort++;
    n_cmp++;
    if (GrantIn !== 1'b0 || Abort !== 1'b1 || Cntr !== 3'(m_cnt)) begin
      n_bad++;
      $display("FAIL to_fire: got g%b a%b c%0d want g0 a1 c%0d",
               GrantIn, Abort, Cntr, m_cnt);
    end
    cyc(1);
    n_cmp++;
    if (Abort !== 1'b0) begin
      n_bad++;
      $display("FAIL to_pulse: got %b want 0", Abort);
    end
`ifdef LANE_STATS_EN
    n_cmp++;
    if (AbortCnt !== 8'(m_abort)) begin
      n_bad++;
      $display("FAIL to_abortcnt: got %0d want %0d", AbortCnt, m_abort);
    end
`endif
  endtask

  task automatic test_backtrack;
    logic [1:0] seq [4];
    seq = '{2'b10, 2'b11, 2'b10, 2'b00};
    ReqIn = 1'b1;
    cyc(1);
    ReqIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Din = seq[i];
      cyc(1);
    end
    n_cmp++;
    if (GrantIn !== 1'b1 || Cntr !== 3'(m_cnt)) begin
      n_bad++;
      $display("FAIL bt_hold: got g%b c%0d want g1 c%0d",
               GrantIn, Cntr, m_cnt);
    end
    cyc(14);
    n_cmp++;
    if (GrantIn !== 1'b1) begin
      n_bad++;
      $display("FAIL bt_timer_restart: got %b want 1", GrantIn);
    end
    cyc(1);
    m_abort++;
    n_cmp++;
    if (GrantIn !== 1'b0 || Abort !== 1'b1 || Cntr !== 3'(m_cnt)) begin
      n_bad++;
      $display("FAIL bt_abort: got g%b a%b c%0d want g0 a1 c%0d",
               GrantIn, Abort, Cntr, m_cnt);
    end
    cyc(1);
`ifdef LANE_STATS_EN
    n_cmp++;
    if (AbortCnt !== 8'(m_abort)) begin
      n_bad++;
      $display("FAIL bt_abortcnt: got %0d want %0d", AbortCnt, m_abort);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic [2:0] ec;
    ReqIn = 1'b1;
    cyc(1);
    ReqIn = 1'b0;
    drive_passage(1'b1);
    ec = 3'(exp_q.pop_front());
    n_cmp++;
    if (Cntr !== ec) begin
      n_bad++;
      $display("FAIL rm_setup_cntr: got %0d want %0d", Cntr, ec);
    end
    cyc(1);
`ifdef LANE_STATS_EN
    n_cmp++;
    if (TotalIn !== 8'(m_total)) begin
      n_bad++;
      $display("FAIL totalin: got %0d want %0d", TotalIn, m_total);
    end
`endif
    ReqIn = 1'b1;
    cyc(1);
    ReqIn = 1'b0;
    Din = 2'b10;
    cyc(1);
    Din = 2'b11;
    cyc(1);
    Rst = 1'b1;
    Din = 2'b01;
    cyc(1);
    Rst = 1'b0;
    m_cnt = 0;
    m_total = 0;
    m_abort = 0;
    n_cmp++;
    if (GrantIn !== 1'b0 || GrantOut !== 1'b0 || Cntr !== 3'd0) begin
      n_bad++;
      $display("FAIL rm_reset: got g%b%b c%0d want g00 c0",
               GrantIn, GrantOut, Cntr);
    end
    cyc(1);
    Din = 2'b00;
    cyc(2);
    n_cmp++;
    if (Cntr !== 3'(m_cnt) || GrantIn !== 1'b0 || GrantOut !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_no_count: got g%b%b c%0d want g00 c0",
               GrantIn, GrantOut, Cntr);
    end
`ifdef LANE_STATS_EN
    n_cmp++;
    if (TotalIn !== 8'(m_total) || AbortCnt !== 8'(m_abort)) begin
      n_bad++;
      $display("FAIL rm_stats: got %0d/%0d want 0/0", TotalIn, AbortCnt);
    end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_entry();
    test_round_robin();
    test_full_empty();
    test_timeout();
    test_backtrack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
